// File: rtl/pm1_exponent_scheduler.sv
// Stage-1 sequencer for the Pollard p-1 engine: walks the small-prime table up to
// prime_limit, runs the shared exponent finder per prime and streams (base, exponent) pairs.
module pm1_exponent_scheduler #(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int BOUNDARY_W     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BOUNDARY_W-1:0] boundary,
  input  logic [8:0]            prime_limit,
  output logic                  ef_clear,
  output logic                  ef_input_enable,
  output logic [8:0]            ef_base,
  output logic [BOUNDARY_W-1:0] ef_boundary,
  input  logic [7:0]            ef_exponent,
  input  logic                  ef_ready,
  output logic                  out_valid,
  output logic [8:0]            out_base,
  output logic [7:0]            out_exponent,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_dbg
);

  // Handshake: a pair transfers on a rising edge where out_valid && out_ready; while
  // out_valid is high, out_base/out_exponent hold and out_valid never drops without a transfer.

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] LAST_IDX = 7'd96;

  localparam logic [8:0] PRIMES [0:96] = '{
    9'd2,   9'd3,   9'd5,   9'd7,   9'd11,  9'd13,  9'd17,  9'd19,  9'd23,  9'd29,
    9'd31,  9'd37,  9'd41,  9'd43,  9'd47,  9'd53,  9'd59,  9'd61,  9'd67,  9'd71,
    9'd73,  9'd79,  9'd83,  9'd89,  9'd97,  9'd101, 9'd103, 9'd107, 9'd109, 9'd113,
    9'd127, 9'd131, 9'd137, 9'd139, 9'd149, 9'd151, 9'd157, 9'd163, 9'd167, 9'd173,
    9'd179, 9'd181, 9'd191, 9'd193, 9'd197, 9'd199, 9'd211, 9'd223, 9'd227, 9'd229,
    9'd233, 9'd239, 9'd241, 9'd251, 9'd257, 9'd263, 9'd269, 9'd271, 9'd277, 9'd281,
    9'd283, 9'd293, 9'd307, 9'd311, 9'd313, 9'd317, 9'd331, 9'd337, 9'd347, 9'd349,
    9'd353, 9'd359, 9'd367, 9'd373, 9'd379, 9'd383, 9'd389, 9'd397, 9'd401, 9'd409,
    9'd419, 9'd421, 9'd431, 9'd433, 9'd439, 9'd443, 9'd449, 9'd457, 9'd461, 9'd463,
    9'd467, 9'd479, 9'd487, 9'd491, 9'd499, 9'd503, 9'd509
  };

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARM, S_RUN, S_EMIT, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t                state, state_nx;
  logic [6:0]            idx;
  logic [6:0]            idx_inc;
  logic [BOUNDARY_W-1:0] bound_q;
  logic [8:0]            limit_q;
  logic [7:0]            exp_q;
  logic [CNT_W-1:0]      cnt;
  logic [8:0]            cur_prime;
  logic [8:0]            nxt_prime;

  function automatic logic [8:0] prime_at(input logic [6:0] i);
    if (i <= LAST_IDX) return PRIMES[i];
    return 9'd0;
  endfunction

  assign idx_inc   = idx + 7'd1;
  assign cur_prime = prime_at(idx);
  assign nxt_prime = prime_at(idx_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (prime_limit < 9'd2) ? S_DONE : S_CLEAR;
      S_CLEAR: state_nx = S_ARM;
      // ARM deliberately ignores ef_ready so a result left over from the previous job is never taken.
      S_ARM:   state_nx = S_RUN;
      S_RUN: begin
        if (ef_ready)             state_nx = (ef_exponent == 8'd0) ? S_NEXT : S_EMIT;
        else if (cnt == CNT_LAST) state_nx = S_ERROR;
      end
      S_EMIT:  if (out_ready) state_nx = S_NEXT;
      S_NEXT:  state_nx = ((idx == LAST_IDX) || (nxt_prime > limit_q)) ? S_DONE : S_CLEAR;
      S_DONE:  state_nx = S_IDLE;
      S_ERROR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= 7'd0;
      bound_q <= '0;
      limit_q <= 9'd0;
      exp_q   <= 8'd0;
      cnt     <= '0;
      busy    <= 1'b0;
      error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          bound_q <= boundary;
          limit_q <= prime_limit;
          idx     <= 7'd0;
          error   <= 1'b0;
          busy    <= 1'b1;
        end
        S_ARM: cnt <= '0;
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (ef_ready) exp_q <= ef_exponent;
        end
        S_NEXT: idx <= idx_inc;
        S_DONE: busy <= 1'b0;
        S_ERROR: begin
          error <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ef_clear        = 1'b0;
    ef_input_enable = 1'b0;
    ef_base         = 9'd0;
    out_valid       = 1'b0;
    out_base        = 9'd0;
    out_exponent    = 8'd0;
    done            = 1'b0;
    case (state)
      S_CLEAR: begin
        ef_clear = 1'b1;
        ef_base  = cur_prime;
      end
      S_ARM, S_RUN: begin
        ef_input_enable = 1'b1;
        ef_base         = cur_prime;
      end
      S_EMIT: begin
        out_valid    = 1'b1;
        out_base     = cur_prime;
        out_exponent = exp_q;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign ef_boundary = bound_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_pm1_exponent_scheduler.sv
// Bench for pm1_exponent_scheduler: behavioural exponent finder, directed jobs,
// and a scoreboard monitor that checks every transferred (base, exponent) pair.
module tb_pm1_exponent_scheduler;

  localparam int W = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] boundary = 64'd0;
  logic [8:0]  prime_limit = 9'd0;
  logic        ef_clear, ef_input_enable;
  logic [8:0]  ef_base;
  logic [63:0] ef_boundary;
  logic [7:0]  ef_exponent;
  logic        ef_ready;
  logic        out_valid;
  logic [8:0]  out_base;
  logic [7:0]  out_exponent;
  logic        out_ready = 1'b1;
  logic        busy, done, error;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  int done_cnt = 0, clear_cnt = 0, en_cnt = 0, pair_cnt = 0;
  logic [8:0] last_base = 9'd0;

  pm1_exponent_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .boundary(boundary),
    .prime_limit(prime_limit), .ef_clear(ef_clear), .ef_input_enable(ef_input_enable),
    .ef_base(ef_base), .ef_boundary(ef_boundary), .ef_exponent(ef_exponent),
    .ef_ready(ef_ready), .out_valid(out_valid), .out_base(out_base),
    .out_exponent(out_exponent), .out_ready(out_ready), .busy(busy), .done(done),
    .error(error), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural exponent finder
  logic         hang_mode = 1'b0;
  logic         stale_mode = 1'b0;
  logic         m_pend = 1'b0;
  logic         m_ready = 1'b0;
  logic [7:0]   m_exp = 8'd0;
  logic [127:0] m_prod = 128'd1;

  assign ef_ready    = m_ready;
  assign ef_exponent = m_exp;

  always @(posedge clk) begin
    if (m_pend) begin
      m_pend <= 1'b0; m_ready <= 1'b0; m_exp <= 8'd0; m_prod <= 128'd1;
    end else if (ef_clear) begin
      if (stale_mode) begin
        m_pend <= 1'b1; m_ready <= 1'b1; m_exp <= 8'd99;
      end else begin
        m_ready <= 1'b0; m_exp <= 8'd0; m_prod <= 128'd1;
      end
    end else if (ef_input_enable && !m_ready && !hang_mode) begin
      if (m_prod >= {64'd0, ef_boundary}) m_ready <= 1'b1;
      else begin
        m_prod <= m_prod * {119'd0, ef_base};
        m_exp  <= m_exp + 8'd1;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (ef_clear) clear_cnt++;
      if (ef_input_enable) en_cnt++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL pair_unexpected: got base=%0d exp=%0d, required no pair", out_base, out_exponent);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({out_base, out_exponent} !== e) begin
            n_errors++;
            $display("FAIL pair: got base=%0d exp=%0d, required base=%0d exp=%0d",
                     out_base, out_exponent, e[16:8], e[7:0]);
          end
        end
        pair_cnt++;
        last_base = out_base;
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_pair(input int b, input int e);
    exp_q.push_back({9'(b), 8'(e)});
  endtask

  task automatic start_job(input logic [63:0] b, input logic [8:0] l);
    @(posedge clk); #1;
    boundary = b; prime_limit = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (state_dbg == 3'd0 && !busy) return;
    end
    n_checks++; n_errors++;
    $display("FAIL %s_timeout: got still busy after %0d cycles, required idle", name, max_cycles);
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    n_checks++; n_errors++;
    $display("FAIL %s_timeout: got no out_valid in %0d cycles, required out_valid", name, max_cycles);
  endtask

  task automatic check_drained(input string name);
    check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int d0, c0, e0, p0;
    bit is_p;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ef_clear", 64'(ef_clear), 64'd0);
    check("rst_ef_en", 64'(ef_input_enable), 64'd0);
    check("rst_ef_base", 64'(ef_base), 64'd0);
    check("rst_ef_boundary", ef_boundary, 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;

    // B=100, limit 10, free-flowing output
    d0 = done_cnt;
    push_pair(2, 7); push_pair(3, 5); push_pair(5, 3); push_pair(7, 3);
    start_job(64'd100, 9'd10);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ef_boundary", ef_boundary, 64'd100);
    wait_idle("t1", 500);
    check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_error", 64'(error), 64'd0);
    check_drained("t1");

    // B=1: every exponent is 0, nothing emitted
    d0 = done_cnt; c0 = clear_cnt; p0 = pair_cnt;
    start_job(64'd1, 9'd10);
    wait_idle("t2", 500);
    check("t2_primes", 64'(clear_cnt - c0), 64'd4);
    check("t2_pairs", 64'(pair_cnt - p0), 64'd0);
    check("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t2_error", 64'(error), 64'd0);

    // back-pressure on the first pair
    out_ready = 1'b0;
    push_pair(2, 7); push_pair(3, 5); push_pair(5, 3); push_pair(7, 3);
    start_job(64'd100, 9'd10);
    wait_valid("t3", 100);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_base", 64'(out_base), 64'd2);
      check("t3_hold_exp", 64'(out_exponent), 64'd7);
      if (i < 4) @(negedge clk);
    end
    check("t3_no_pop_while_stalled", 64'(exp_q.size()), 64'd4);
    out_ready = 1'b1;
    wait_idle("t3", 500);
    check_drained("t3");

    // finder hangs: timeout after 128 RUN cycles
    hang_mode = 1'b1;
    d0 = done_cnt; e0 = en_cnt;
    start_job(64'd100, 9'd10);
    wait_idle("t4", 400);
    check("t4_enable_cycles", 64'(en_cnt - e0), 64'd129);
    check("t4_error", 64'(error), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_ef_en", 64'(ef_input_enable), 64'd0);
    check("t4_done_pulses", 64'(done_cnt - d0), 64'd0);
    hang_mode = 1'b0;

    // start clears error; prime_limit=1 finishes one cycle after start
    d0 = done_cnt; p0 = pair_cnt;
    start_job(64'd1, 9'd1);
    check("t6_error_cleared", 64'(error), 64'd0);
    @(negedge clk);
    check("t6_done_next_cycle", 64'(done), 64'd1);
    wait_idle("t6", 20);
    check("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t6_pairs", 64'(pair_cnt - p0), 64'd0);

    // stale ready at ARM, and start while busy
    stale_mode = 1'b1;
    push_pair(2, 7); push_pair(3, 5);
    start_job(64'd100, 9'd3);
    repeat (3) @(posedge clk);
    #1 boundary = 64'd5; prime_limit = 9'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("t5_boundary_kept", ef_boundary, 64'd100);
    wait_idle("t5", 500);
    check_drained("t5");
    stale_mode = 1'b0;

    // reset in the middle of EMIT
    out_ready = 1'b0;
    start_job(64'd100, 9'd10);
    wait_valid("t7", 100);
    #2 reset = 1'b1;
    #1;
    check("t7_valid_on_reset", 64'(out_valid), 64'd0);
    check("t7_state_on_reset", 64'(state_dbg), 64'd0);
    check("t7_busy_on_reset", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();

    // every prime to 509 with B=2
    p0 = pair_cnt;
    for (int p = 2; p <= 511; p++) begin
      is_p = 1'b1;
      for (int q = 2; q * q <= p; q++) if (p % q == 0) is_p = 1'b0;
      if (is_p) push_pair(p, 1);
    end
    start_job(64'd2, 9'd511);
    wait_idle("t8", 5000);
    check("t8_pairs", 64'(pair_cnt - p0), 64'd97);
    check("t8_last_base", 64'(last_base), 64'd509);
    check_drained("t8");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
